// File: rtl/dequant_zigzag.sv
// Dequantizes a zigzag-ordered 8x8 coefficient block into a natural-order buffer, then streams it out row by row.
// Define DEQUANT_SAT_EN to saturate products to -128..127; the default build keeps the low 8 bits (wrap).
module dequant_zigzag #(
    parameter int COEF_W = 12,
    parameter int QW     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic signed [COEF_W-1:0] in_coef,
    output logic                     in_ready,
    input  logic                     q_wr,
    input  logic [5:0]               q_addr,
    input  logic [QW-1:0]            q_data,
    input  logic                     out_ready,
    output logic                     out_wr,
    output logic [2:0]               out_add,
    output logic [7:0]               out_data,
    output logic [2:0]               out_row,
    output logic                     row_done
);

    localparam int PW = COEF_W + QW + 1;

    localparam logic [5:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic {FILL, DRAIN} state_t;

    state_t                state;
    logic [5:0]            cnt;
    logic                  last_row;
    logic [QW-1:0]         qtab [64];
    logic [7:0]            sbuf [64];
    logic [5:0]            zz_pos;
    logic signed [PW-1:0]  coef_ext;
    logic signed [PW-1:0]  q_ext;
    logic signed [PW-1:0]  prod;
    logic                  xfer;
    logic [2:0]            next_add;

    function automatic logic [7:0] reduce8(input logic signed [PW-1:0] p);
`ifdef DEQUANT_SAT_EN
        if (p > PW'(127))
            return 8'h7f;
        else if (p < PW'(-128))
            return 8'h80;
        else
            return p[7:0];
`else
        return p[7:0];
`endif
    endfunction

    assign in_ready = (state == FILL);
    assign xfer     = in_valid && in_ready;
    assign zz_pos   = ZZ[cnt];
    assign coef_ext = PW'(in_coef);
    // The table entry is read before this cycle's q_wr lands, so a same-cycle write affects only later transfers.
    assign q_ext    = PW'(qtab[zz_pos]);
    assign prod     = coef_ext * q_ext;
    assign next_add = out_add + 3'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 64; i++)
                qtab[i] <= QW'(1);
        end else if (q_wr) begin
            qtab[q_addr] <= q_data;
        end
    end

    always_ff @(posedge clk) begin
        if (xfer && reset)
            sbuf[zz_pos] <= reduce8(prod);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= FILL;
            cnt      <= 6'd0;
            last_row <= 1'b0;
            out_wr   <= 1'b0;
            out_add  <= 3'd0;
            out_data <= 8'd0;
            out_row  <= 3'd0;
            row_done <= 1'b0;
        end else begin
            row_done <= 1'b0;
            case (state)
                FILL: begin
                    if (xfer) begin
                        cnt <= cnt + 6'd1;
                        if (cnt == 6'd63) begin
                            state    <= DRAIN;
                            out_row  <= 3'd0;
                            last_row <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (out_wr) begin
                        if (out_add == 3'd7) begin
                            out_wr   <= 1'b0;
                            out_add  <= 3'd0;
                            out_data <= 8'd0;
                            row_done <= 1'b1;
                            last_row <= (out_row == 3'd7);
                            if (out_row != 3'd7)
                                out_row <= out_row + 3'd1;
                        end else begin
                            out_add  <= next_add;
                            out_data <= sbuf[{out_row, next_add}];
                        end
                    end else if (row_done && last_row) begin
                        // Block fully delivered: hand the buffer back to the input side.
                        state    <= FILL;
                        cnt      <= 6'd0;
                        out_row  <= 3'd0;
                        last_row <= 1'b0;
                    end else if (out_ready) begin
                        out_wr   <= 1'b1;
                        out_add  <= 3'd0;
                        out_data <= sbuf[{out_row, 3'd0}];
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_dequant_zigzag.sv
// Directed bench for dequant_zigzag: a behavioural model fills a scoreboard per block, a negedge monitor pops and checks.
module tb_dequant_zigzag;

    typedef struct packed {
        logic [2:0] row;
        logic [2:0] col;
        logic [7:0] data;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [11:0] in_coef = '0;
    logic               in_ready;
    logic               q_wr = 1'b0;
    logic [5:0]         q_addr = '0;
    logic [7:0]         q_data = '0;
    logic               out_ready = 1'b1;
    logic               out_wr;
    logic [2:0]         out_add;
    logic [7:0]         out_data;
    logic [2:0]         out_row;
    logic               row_done;

    int checks = 0;
    int errors = 0;
    int rows_seen = 0;
    int zz [64];
    int q_model [64];
    logic signed [11:0] coefs [64];
    logic [7:0] exp_buf [64];
    logic [7:0] cap [64];
    exp_t sb [$];
    logic prev_last = 1'b0;

    dequant_zigzag #(.COEF_W(12), .QW(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_coef(in_coef),
        .in_ready(in_ready), .q_wr(q_wr), .q_addr(q_addr), .q_data(q_data),
        .out_ready(out_ready), .out_wr(out_wr), .out_add(out_add),
        .out_data(out_data), .out_row(out_row), .row_done(row_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_red(input int c, input int q);
        int p;
        logic [7:0] r;
        p = c * q;
`ifdef DEQUANT_SAT_EN
        if (p > 127) p = 127;
        if (p < -128) p = -128;
`endif
        r = p[7:0];
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset) begin
            if (out_wr) begin
                cap[{out_row, out_add}] = out_data;
                if (sb.size() == 0) begin
                    chk("unexpected_sample", 32'({out_row, out_add, out_data}), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sample", 32'({out_row, out_add, out_data}), 32'({e.row, e.col, e.data}));
                end
            end else begin
                chk("idle_zero", 32'({out_add, out_data}), 32'd0);
            end
            chk("row_done_timing", 32'(row_done), 32'(prev_last));
            prev_last = out_wr && (out_add == 3'd7);
            if (row_done) rows_seen++;
        end else begin
            prev_last = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic q_write(input int addr, input int data);
        q_wr = 1'b1;
        q_addr = 6'(addr);
        q_data = 8'(data);
        tick();
        q_wr = 1'b0;
        q_model[addr] = data;
    endtask

    task automatic feed(input bit qw0, input int qwd);
        rows_seen = 0;
        for (int k = 0; k < 64; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                tick();
            end
            chk("in_ready_fill", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_coef = coefs[k];
            if (qw0 && k == 0) begin
                q_wr = 1'b1;
                q_addr = 6'd0;
                q_data = 8'(qwd);
            end
            exp_buf[zz[k]] = model_red(int'(coefs[k]), q_model[zz[k]]);
            tick();
            if (qw0 && k == 0) begin
                q_wr = 1'b0;
                q_model[0] = qwd;
            end
        end
        in_valid = 1'b0;
        chk("in_ready_drain", 32'(in_ready), 32'd0);
        for (int n = 0; n < 64; n++) begin
            exp_t e;
            e.row = 3'(n / 8);
            e.col = 3'(n % 8);
            e.data = exp_buf[n];
            sb.push_back(e);
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while (rows_seen < 8 && c < 400) begin
            tick();
            c++;
        end
        chk("rows_done", 32'(rows_seen), 32'd8);
        chk("queue_empty", 32'(sb.size()), 32'd0);
        chk("in_ready_back", 32'(in_ready), 32'd1);
    endtask

    task automatic rand_coefs();
        for (int k = 0; k < 64; k++)
            coefs[k] = 12'($urandom_range(0, 4095));
    endtask

    initial begin
        int idx;
        int c;
        idx = 0;
        for (int s = 0; s < 15; s++) begin
            int lo, hi;
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            if (s % 2 == 0)
                for (int r = hi; r >= lo; r--) begin zz[idx] = r * 8 + (s - r); idx++; end
            else
                for (int r = lo; r <= hi; r++) begin zz[idx] = r * 8 + (s - r); idx++; end
        end
        for (int i = 0; i < 64; i++) q_model[i] = 1;

        // Reset with in_valid high: nothing may be recorded.
        in_valid = 1'b1;
        in_coef = 12'sd99;
        repeat (3) tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_wr", 32'(out_wr), 32'd0);
        chk("rst_out_add", 32'(out_add), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_row", 32'(out_row), 32'd0);
        chk("rst_row_done", 32'(row_done), 32'd0);
        in_valid = 1'b0;
        reset = 1'b1;
        tick();

        // Ramp block.
        for (int k = 0; k < 64; k++) coefs[k] = 12'(k);
        feed(1'b0, 0);
        wait_drain();
        chk("ramp_r0c0", 32'(cap[0]), 32'd0);
        chk("ramp_r0c1", 32'(cap[1]), 32'd1);
        chk("ramp_r0c2", 32'(cap[2]), 32'd5);
        chk("ramp_r0c3", 32'(cap[3]), 32'd6);
        chk("ramp_r0c4", 32'(cap[4]), 32'd14);
        chk("ramp_r0c5", 32'(cap[5]), 32'd15);
        chk("ramp_r0c6", 32'(cap[6]), 32'd27);
        chk("ramp_r0c7", 32'(cap[7]), 32'd28);

        // DC only with q[0]=16.
        q_write(0, 16);
        for (int k = 0; k < 64; k++) coefs[k] = 12'sd0;
        coefs[0] = 12'sd5;
        feed(1'b0, 0);
        wait_drain();
        chk("dc_80", 32'(cap[0]), 32'd80);
        chk("dc_other", 32'(cap[9]), 32'd0);

        // Overflow reduction and zero table entry.
        q_write(0, 100);
        q_write(1, 100);
        q_write(2, 0);
        rand_coefs();
        coefs[0] = 12'sd3;
        coefs[1] = -12'sd3;
        coefs[5] = 12'sd77;
        q_write(9, 200);
        feed(1'b0, 0);
        wait_drain();
`ifdef DEQUANT_SAT_EN
        chk("red_pos", 32'(cap[0]), 32'd127);
        chk("red_neg", 32'(cap[1]), 32'h80);
`else
        chk("red_pos", 32'(cap[0]), 32'h2C);
        chk("red_neg", 32'(cap[1]), 32'hD4);
`endif
        chk("q_zero", 32'(cap[2]), 32'd0);

        // Back-pressure: hold out_ready low, then drop it mid-row.
        out_ready = 1'b0;
        rand_coefs();
        feed(1'b0, 0);
        repeat (5) tick();
        chk("stall_out_wr", 32'(out_wr), 32'd0);
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("start_out_wr", 32'(out_wr), 32'd1);
        chk("start_row", 32'(out_row), 32'd0);
        tick();
        tick();
        out_ready = 1'b0;
        repeat (15) tick();
        chk("midrow_queue", 32'(sb.size()), 32'd56);
        chk("midrow_idle", 32'(out_wr), 32'd0);
        out_ready = 1'b1;
        wait_drain();

        // Reset during row 3 column 4.
        rand_coefs();
        feed(1'b0, 0);
        c = 0;
        while (!(out_wr && out_row == 3'd3 && out_add == 3'd4) && c < 200) begin
            tick();
            c++;
        end
        chk("reach_r3c4", 32'({out_wr, out_row, out_add}), 32'({1'b1, 3'd3, 3'd4}));
        reset = 1'b0;
        #1;
        chk("abort_out_wr", 32'(out_wr), 32'd0);
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        for (int i = 0; i < 64; i++) q_model[i] = 1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_out_wr", 32'(out_wr), 32'd0);
        rand_coefs();
        feed(1'b0, 0);
        wait_drain();

        // Same-cycle table write and transfer on entry 0.
        rand_coefs();
        coefs[0] = 12'sd2;
        feed(1'b1, 9);
        wait_drain();
        chk("old_q_used", 32'(cap[0]), 32'd2);
        feed(1'b0, 0);
        wait_drain();
        chk("new_q_used", 32'(cap[0]), 32'd18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dequant_zigzag.md
DEQUANT_ZIGZAG -- requirements
Module: dequant_zigzag

Interface
REQ-001 SHALL have parameter COEF_W, default 12: signed width of incoming quantized coefficients.
REQ-002 SHALL have parameter QW, default 8: unsigned width of quantization table entries.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port in_valid  input  1  coefficient present on in_coef.
REQ-006 SHALL have port in_coef  input  COEF_W  signed coefficient, zigzag order.
REQ-007 SHALL have port in_ready  output  1  block accepts a coefficient this cycle.
REQ-008 SHALL have port q_wr  input  1  quant table write strobe.
REQ-009 SHALL have port q_addr  input  6  quant table address, natural (row-major) order.
REQ-010 SHALL have port q_data  input  QW  quant table write data.
REQ-011 SHALL have port out_ready  input  1  downstream IDCT free to take a new row.
REQ-012 SHALL have port out_wr  output  1  row sample write strobe (drives IDCT wr).
REQ-013 SHALL have port out_add  output  3  column index within the row (drives IDCT add).
REQ-014 SHALL have port out_data  output  8  dequantized sample (drives IDCT data_in).
REQ-015 SHALL have port out_row  output  3  index of the row being delivered.
REQ-016 SHALL have port row_done  output  1  one-cycle pulse after the 8th sample of a row.

Function
REQ-017 SHALL run a two-state FSM: FILL (accept 64 coefficients) and DRAIN (deliver 8 rows of 8).
REQ-018 in_ready SHALL equal 1 exactly when state is FILL; a transfer occurs when in_valid and in_ready are both 1.
REQ-019 Transfer k (0..63) SHALL store at natural position ZZ[k], the standard JPEG zigzag map (0,1,8,16,9,2,3,10,17,24,...,62,63).
REQ-020 Stored value SHALL be in_coef times q[ZZ[k]], signed full-precision product, reduced to 8 bits per REQ-035.
REQ-021 On transfer k=63 the FSM SHALL enter DRAIN on the next edge with row counter 0; no further transfers until FILL returns.
REQ-022 In DRAIN, a row SHALL start only on a cycle with out_ready=1; then 8 consecutive cycles drive out_wr=1, out_add=0..7, out_data=buf[row*8+out_add], out_row=row.
REQ-023 out_ready SHALL be sampled only at row start; deasserting it mid-row SHALL NOT stall the row.
REQ-024 row_done SHALL pulse 1 cycle on the cycle after out_add=7; the next row may start no earlier than that cycle.
REQ-025 After row_done of row 7 the FSM SHALL return to FILL, coefficient counter 0; in_ready=1 the following cycle.
REQ-026 out_wr, out_add, out_data SHALL be 0 whenever no row sample is being driven.
REQ-027 q_wr SHALL write q[q_addr]=q_data in any state; a q_wr and a transfer to the same entry in one cycle SHALL use the old entry value.
REQ-028 A q entry of 0 SHALL yield stored value 0.

Reset
REQ-029 reset low SHALL asynchronously force state FILL, coefficient and row counters 0, out_wr 0, out_add 0, out_data 0, out_row 0, row_done 0.
REQ-030 in_ready SHALL read 1 during reset, but no transfer SHALL be recorded while reset is low.
REQ-031 All 64 quant entries SHALL reset to 1; sample buffer contents SHALL be don't-care after reset.
REQ-032 Reset asserted mid-FILL or mid-DRAIN SHALL abandon the block; no partial row continues after release.

Configuration
REQ-033 Macro DEQUANT_SAT_EN SHALL select the 8-bit reduction.
REQ-034 With DEQUANT_SAT_EN defined, products SHALL saturate to signed range -128..127.
REQ-035 Without it, stored value SHALL be the low 8 bits of the product (wrap).

Verification
REQ-036 Reset, q all 1, feed in_coef=k for k=0..63, out_ready=1 -> row 0 outputs 0,1,5,6,14,15,27,28; 8 rows, 8 row_done pulses, in_ready back to 1.
REQ-037 q[0]=16, first coef=5, rest 0 -> row 0 column 0 = 80, all other samples 0.
REQ-038 q[0]=100, first coef=3 -> 127 with DEQUANT_SAT_EN, 44 (0x2C) without; coef -3 -> -128 / 0xD4.
REQ-039 Hold out_ready=0 after FILL -> out_wr stays 0, in_ready 0; raise out_ready -> row 0 starts next cycle; drop it mid-row -> row completes.
REQ-040 Assert reset low during DRAIN row 3 column 4 -> out_wr 0 immediately, after release in_ready=1 and next 64 transfers start new block.
REQ-041 Same-cycle q_wr q_addr=0 q_data=9 and transfer k=0 coef=2, prior q[0]=1 -> stored 2; next block same coef -> 18.
